// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: turns a 1-bit LIF spike train back into numbers.
// It counts spikes over fixed windows of enabled cycles to produce a rate
// word, which is held in a one-entry valid/ready buffer. It also measures
// the inter-spike interval between the last two accepted spikes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         decode enable; low freezes window/spike/gap counters
//   spike      spike input, sampled every rising edge
//   rate       spike count of the last closed window (buffered)
//   rate_valid rate holds an unconsumed result
//   rate_ready consumer accepts rate when rate_valid && rate_ready
//   isi        enabled cycles between the last two spikes, saturating
//   isi_valid  set once two spikes have been seen since reset
//   overrun    sticky; a window result was dropped because the buffer was full
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] isi,
  output logic             isi_valid,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] gap;
  logic             seen_one;

  logic             close_c;
  logic             pop_c;
  logic [CNT_W-1:0] result_c;
  logic [CNT_W-1:0] gap_inc_c;

  // Window close, buffer pop and saturating increments
  always_comb begin
    close_c   = en && (win_cnt == WIN_LAST);
    pop_c     = rate_valid && rate_ready;
    result_c  = (spk_cnt == CNT_MAX) ? CNT_MAX : spk_cnt + CNT_W'(spike);
    gap_inc_c = (gap == CNT_MAX) ? CNT_MAX : gap + CNT_W'(1);
  end

  // Window and spike counters; the cycle after a close is window cycle 0
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      spk_cnt <= '0;
    end else if (en) begin
      if (close_c) begin
        win_cnt <= '0;
        spk_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + CNT_W'(1);
        spk_cnt <= result_c;
      end
    end
  end

  // One-entry output buffer; a pop and a load in the same cycle keep valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (close_c && (!rate_valid || pop_c)) begin
      rate       <= result_c;
      rate_valid <= 1'b1;
    end else if (close_c) begin
      overrun    <= 1'b1;
    end else if (pop_c) begin
      rate_valid <= 1'b0;
    end
  end

  // Inter-spike interval; the first spike after reset only arms the measurement
  always_ff @(posedge clk) begin
    if (rst) begin
      gap       <= '0;
      seen_one  <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else if (en) begin
      if (spike) begin
        gap      <= '0;
        seen_one <= 1'b1;
        if (seen_one) begin
          isi       <= gap_inc_c;
          isi_valid <= 1'b1;
        end
      end else begin
        gap <= gap_inc_c;
      end
    end
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Decodes the 1-bit spike train produced by our LIF neurons back into numeric values, as the inverse of the current-to-spike encoding. It counts spikes over fixed windows to give a rate word, and measures the inter-spike interval (ISI) between consecutive spikes. Rate results leave through a one-deep valid/ready output buffer toward the readout/scan logic. One instance sits on each neuron's spike output.

Parameters:
WINDOW, 16, window length in enabled cycles (2..255).
CNT_W, 8, width of rate, ISI and internal counters; all counters saturate at 2^CNT_W-1.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  decode enable; low freezes window/spike/gap counters, spikes ignored
spike  input  1  spike from neuron, sampled each rising edge
rate  output  CNT_W  spike count of last closed window (buffered)
rate_valid  output  1  rate holds an unconsumed result
rate_ready  input  1  consumer accepts rate when rate_valid&&rate_ready
isi  output  CNT_W  cycles between last two accepted spikes, saturating
isi_valid  output  1  high once two spikes seen since reset
overrun  output  1  sticky: a window result was dropped because buffer was full

Behaviour:
- Reset (rst=1 at edge): win_cnt=0, spk_cnt=0, gap=0, rate=0, rate_valid=0, isi=0, isi_valid=0, overrun=0, seen_one=0. rst overrides all other inputs, including mid-window and with rate_valid pending (result discarded).
- Enabled cycle = en=1. Only enabled cycles advance win_cnt, count spikes, or advance gap.
- Window: win_cnt counts 0..WINDOW-1 over enabled cycles. On the closing cycle (en=1, win_cnt==WINDOW-1) the result is spk_cnt + spike (saturated); spk_cnt<=0, win_cnt<=0. Otherwise spk_cnt<=sat(spk_cnt+spike), win_cnt<=win_cnt+1.
- Latency: result visible on rate with rate_valid=1 the cycle after the closing edge.
- Output buffer (one entry), evaluated per edge, with pop = rate_valid&&rate_ready:
  - close && (!rate_valid || pop): rate<=result, rate_valid<=1 (back-to-back: pop and load same cycle, valid stays 1).
  - close && rate_valid && !pop: result dropped, rate held unchanged, overrun<=1.
  - pop && !close: rate_valid<=0, rate holds last value.
  - rate must not change while rate_valid=1 && !rate_ready.
- overrun clears only on rst.
- ISI: gap counts enabled cycles since last spike. Enabled spike: gap<=0. Enabled non-spike cycle: gap<=sat(gap+1).
  - Enabled spike with seen_one=1: isi<=sat(gap+1), isi_valid<=1.
  - First spike after reset only sets seen_one. isi is not handshaken; it updates in place.
  - Adjacent spikes give isi=1.
- en=0: all counters frozen, spike ignored; output handshake (pop) still operates normally.
- Back-to-back windows have no dead cycle: cycle after close is window cycle 0.

Test Plan:
- Reset then en=1, spike every 4th enabled cycle (cycles 3,7,11,15), rate_ready=1 -> rate=4, rate_valid pulses 1 cycle after cycle 15. isi=4, isi_valid=1 after the second spike.
- spike=1 constantly for 2 windows, rate_ready=0 -> first rate=16 held stable with rate_valid=1; second close sets overrun=1 and rate stays 16. Raise ready -> pop, rate_valid=0.
- ready asserted exactly on the second close cycle with a 16-spike then 8-spike window -> rate goes 16->8 with rate_valid continuously 1, overrun=0.
- Spike at cycle 0, en=0 for 10 cycles with spikes toggling, then a spike at the next enabled cycle -> isi=1, window count excludes disabled spikes.
- No spike for 300 enabled cycles then two spikes -> isi=1 (second), earlier gap saturates at 255. Spike, 300 idle cycles, spike -> isi=255.
- rst pulsed mid-window (win_cnt=9, spk_cnt=5) with rate_valid=1 -> all outputs 0 the next cycle. Next rate reflects only spikes after reset.
